aes_uart_frame_ctrl: RTL
========================

// Module: aes_uart_frame_ctrl
// PURPOSE
//  Command-driven byte-stream controller between a UART byte interface and an AES-128 core.
//  Decodes host command bytes (key load / encrypt / decrypt) and assembles key and data bytes.
//  Starts the core with a start/done handshake, then returns the result LSB-first over UART.
//  Has a timeout, protocol error reporting and a selectable cipher direction.
// PARAMETERS
//  BLOCK_BYTES    16    bytes per data block (block width = 8*BLOCK_BYTES)
//  KEY_BYTES      16    bytes per key
//  TX_GAP_CYCLES  1000  idle clk cycles inserted between transmitted bytes (>=1)
//  CORE_TIMEOUT   255   max clk cycles from core_start to core_done before error
// PORTS
//  clk             in   1                clock
//  reset           in   1                asynchronous, active-low reset
//  enable          in   1                level; low = abort and clear key
//  rx_data         in   8                received UART byte
//  rx_valid        in   1                UART byte valid; byte taken on rising edge
//  tx_ready        in   1                UART transmitter idle
//  tx_start        out  1                one-cycle transmit request
//  tx_data         out  8                byte to transmit, valid with tx_start
//  core_key        out  8*KEY_BYTES      key; byte i at [8i+:8]
//  core_block_in   out  8*BLOCK_BYTES    input block; byte i at [8i+:8]
//  core_mode       out  1                0 = encrypt, 1 = decrypt
//  core_start      out  1                one-cycle core start pulse
//  core_done       in   1                core result valid (pulse or level)
//  core_block_out  in   8*BLOCK_BYTES    core result
//  busy            out  1                high in any state other than IDLE
//  key_loaded      out  1                a full key has been received since enable rose
//  err_sticky      out  1                set on timeout/bad command/no key; cleared by enable low
// BEHAVIOUR
//  Reset values: all outputs, registers, key, block and counters are 0; state = IDLE.
//  Commands: 0x4B 'K' load key, 0x45 'E' encrypt, 0x44 'D' decrypt. Responses: ACK 0x06, ERR 0x15.
//  Bytes stored in arrival order: first byte -> byte 0.
//  FSM (all transitions in one cycle unless stated):
//   IDLE:     enable=1 -> CMD.
//   CMD:      next byte: 'K' -> RX_KEY.
//             'E'/'D' with key_loaded -> RX_BLK, core_mode latched.
//             'E'/'D' without key_loaded, or any other value -> TX_ERR, err_sticky=1.
//   RX_KEY:   after KEY_BYTES bytes -> key_loaded=1 -> TX_ACK.
//   RX_BLK:   after BLOCK_BYTES bytes -> START.
//   START:    core_start=1 for exactly one cycle -> WAIT_CORE; timeout counter cleared.
//   WAIT_CORE: core_done=1 -> capture core_block_out -> TX_BYTE.
//             counter==CORE_TIMEOUT -> TX_ERR, err_sticky=1.
//   TX_BYTE:  wait for tx_ready=1, pulse tx_start one cycle -> TX_WAIT.
//   TX_WAIT:  wait for tx_ready to fall, then rise -> TX_GAP.
//   TX_GAP:   wait TX_GAP_CYCLES cycles.
//             More bytes left -> TX_BYTE; else -> CMD.
//   TX_ACK / TX_ERR: send the single 0x06 / 0x15 byte via the TX_BYTE/TX_WAIT path -> CMD.
//  Latency: core_start is 2 cycles after the rising edge of rx_valid for the last block byte.
//  Result bytes go out in order 0..BLOCK_BYTES-1.
//  rx_valid edges in START, WAIT_CORE or any TX state are dropped; they are not counted.
//  Simultaneous core_done and timeout expiry: core_done wins.
//  A partial key is not used: key_loaded stays 0 until all KEY_BYTES are received.
//  A new 'K' command clears key_loaded at its first byte.
//  enable low in any state: next cycle -> IDLE.
//   Cleared: tx_start, core_start, counters, key, key_loaded, err_sticky.
//   Any transmission in progress is abandoned after the current UART byte.
//  Byte counters are $clog2(max(BLOCK_BYTES,KEY_BYTES)+1) bits wide.
//  Byte counters wrap to 0 on every block boundary.
// CONFIGURATION
//  AES_UART_CRC8_EN defined: one extra byte is sent after every result block.
//   CRC-8 over the result bytes: poly 0x07, init 0x00, no reflection, no final XOR.
//   The CRC byte uses the same TX_BYTE/TX_GAP path.
//  Not defined: only BLOCK_BYTES result bytes are sent; no CRC logic is instantiated.
// STRUCTURE
//  aes_uart_pkg: state enum (IDLE..TX_ERR), CMD_KEY/CMD_ENC/CMD_DEC, ACK_BYTE/ERR_BYTE, crc8 step function.
//  Sub-module aes_uart_crc8: byte-serial CRC-8 with clear and update inputs.
//   Present only under AES_UART_CRC8_EN.
// TESTING
//  1. 'K' + key 000102..0F, then 'E' + 00112233..EEFF -> ACK 0x06.
//     Expected: core_mode=0, core_start pulse, 16 bytes 69 C4 E0 D8 6A 7B 04 30 D8 CD B7 80 70 B4 C5 5A.
//  2. 'D' + block 69C4..C55A with the same key -> core_mode=1; 16 bytes returned 00 11 22 .. FF.
//  3. 'E' with no key loaded -> single 0x15; err_sticky=1; core_start never asserted.
//  4. Core model never raises done -> 0x15 sent exactly CORE_TIMEOUT+1 cycles after core_start.
//  5. enable dropped after 7 key bytes -> IDLE next cycle; key_loaded=0; err_sticky=0.
//     Re-enable + full key -> ACK.
//  6. With AES_UART_CRC8_EN, case 1 -> 17th byte equals CRC-8 of the 16 result bytes.
//     Without it, exactly 16 bytes; gaps between bytes >= TX_GAP_CYCLES.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the AES UART frame controller.
// The CRC helper is used only when AES_UART_CRC8_EN is defined.
package aes_uart_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StCmd,
        StRxKey,
        StRxBlk,
        StStart,
        StWaitCore,
        StTxByte,
        StTxWait,
        StTxGap,
        StTxAck,
        StTxErr
    } state_e;

    localparam logic [7:0] CMD_KEY   = 8'h4B;
    localparam logic [7:0] CMD_ENC   = 8'h45;
    localparam logic [7:0] CMD_DEC   = 8'h44;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] ERR_BYTE  = 8'h15;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One byte of CRC-8: MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/aes_uart_crc8.sv
// Byte-serial CRC-8 accumulator for the result stream.
// Compiled only when AES_UART_CRC8_EN is defined.
`ifdef AES_UART_CRC8_EN
module aes_uart_crc8
    import aes_uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       upd_i,
    input  logic [7:0] data_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q, crc_d;

    // Clear has priority so a new block always starts from 0x00.
    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = 8'h00;
        end else if (upd_i) begin
            crc_d = crc8_step(crc_q, data_i);
        end
    end

    // CRC state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule
`endif

// File: rtl/aes_uart_frame_ctrl.sv
// Command-driven UART byte-stream controller in front of an AES-128 core.
// Define AES_UART_CRC8_EN to append a CRC-8 byte after every result block.
module aes_uart_frame_ctrl
    import aes_uart_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES   = 16,
    parameter int unsigned KEY_BYTES     = 16,
    parameter int unsigned TX_GAP_CYCLES = 1000,
    parameter int unsigned CORE_TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable_i,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_valid_i,
    input  logic                     tx_ready_i,
    output logic                     tx_start_o,
    output logic [7:0]               tx_data_o,
    output logic [8*KEY_BYTES-1:0]   core_key_o,
    output logic [8*BLOCK_BYTES-1:0] core_block_in_o,
    output logic                     core_mode_o,
    output logic                     core_start_o,
    input  logic                     core_done_i,
    input  logic [8*BLOCK_BYTES-1:0] core_block_out_i,
    output logic                     busy_o,
    output logic                     key_loaded_o,
    output logic                     err_sticky_o
);

    localparam int unsigned MaxBytes = (BLOCK_BYTES > KEY_BYTES) ? BLOCK_BYTES : KEY_BYTES;
    localparam int unsigned CntW     = $clog2(MaxBytes + 1);
    localparam int unsigned TmoW     = $clog2(CORE_TIMEOUT + 2);
    localparam int unsigned GapW     = $clog2(TX_GAP_CYCLES + 1);

    localparam logic [CntW-1:0] KeyLast  = CntW'(KEY_BYTES - 1);
    localparam logic [CntW-1:0] BlkLast  = CntW'(BLOCK_BYTES - 1);
    localparam logic [TmoW-1:0] TmoLimit = TmoW'(CORE_TIMEOUT);
    localparam logic [GapW-1:0] GapLast  = GapW'(TX_GAP_CYCLES - 1);
`ifdef AES_UART_CRC8_EN
    localparam logic [CntW-1:0] CrcIdx   = CntW'(BLOCK_BYTES);
    localparam logic [CntW-1:0] TxLast   = CrcIdx;
`else
    localparam logic [CntW-1:0] TxLast   = BlkLast;
`endif

    state_e                   state_q;
    logic                     rx_valid_q;
    logic [CntW-1:0]          byte_cnt_q;
    logic [TmoW-1:0]          tmo_cnt_q;
    logic [GapW-1:0]          gap_cnt_q;
    logic [8*KEY_BYTES-1:0]   key_q;
    logic [8*BLOCK_BYTES-1:0] blk_q;
    logic [8*BLOCK_BYTES-1:0] res_q;
    logic                     mode_q;
    logic                     key_loaded_q;
    logic                     err_q;
    logic                     tx_start_q;
    logic [7:0]               tx_data_q;
    logic                     core_start_q;
    logic                     tx_seen_low_q;
    logic                     tx_single_q;

    logic                     rx_pulse;
    logic [7:0]               res_byte;
    logic [7:0]               tx_byte;

    assign rx_pulse = rx_valid_i & ~rx_valid_q;

    // Pick the result byte addressed by the byte counter.
    always_comb begin
        res_byte = 8'h00;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (byte_cnt_q == CntW'(i)) begin
                res_byte = res_q[8*i +: 8];
            end
        end
    end

`ifdef AES_UART_CRC8_EN
    logic       crc_clr;
    logic       crc_upd;
    logic [7:0] crc_val;

    // CRC restarts on result capture and absorbs each result byte as it is launched.
    assign crc_clr = enable_i && (state_q == StWaitCore) && core_done_i;
    assign crc_upd = enable_i && (state_q == StTxByte) && tx_ready_i && (byte_cnt_q != CrcIdx);
    assign tx_byte = (byte_cnt_q == CrcIdx) ? crc_val : res_byte;

    aes_uart_crc8 u_crc8 (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (crc_clr),
        .upd_i  (crc_upd),
        .data_i (res_byte),
        .crc_o  (crc_val)
    );
`else
    assign tx_byte = res_byte;
`endif

    // Main controller FSM; all outputs are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            rx_valid_q    <= 1'b0;
            byte_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            key_q         <= '0;
            blk_q         <= '0;
            res_q         <= '0;
            mode_q        <= 1'b0;
            key_loaded_q  <= 1'b0;
            err_q         <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            core_start_q  <= 1'b0;
            tx_seen_low_q <= 1'b0;
            tx_single_q   <= 1'b0;
        end else begin
            rx_valid_q   <= rx_valid_i;
            tx_start_q   <= 1'b0;
            core_start_q <= 1'b0;
            if (!enable_i) begin
                state_q      <= StIdle;
                byte_cnt_q   <= '0;
                tmo_cnt_q    <= '0;
                gap_cnt_q    <= '0;
                key_q        <= '0;
                key_loaded_q <= 1'b0;
                err_q        <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: state_q <= StCmd;
                    StCmd: begin
                        if (rx_pulse) begin
                            byte_cnt_q <= '0;
                            if (rx_data_i == CMD_KEY) begin
                                state_q <= StRxKey;
                            end else if ((rx_data_i == CMD_ENC || rx_data_i == CMD_DEC)
                                         && key_loaded_q) begin
                                mode_q  <= (rx_data_i == CMD_DEC);
                                state_q <= StRxBlk;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= StTxErr;
                            end
                        end
                    end
                    StRxKey: begin
                        if (rx_pulse) begin
                            key_q[8*int'(byte_cnt_q) +: 8] <= rx_data_i;
                            // A partial key must never look valid.
                            if (byte_cnt_q == '0) key_loaded_q <= 1'b0;
                            if (byte_cnt_q == KeyLast) begin
                                byte_cnt_q   <= '0;
                                key_loaded_q <= 1'b1;
                                state_q      <= StTxAck;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + CntW'(1);
                            end
                        end
                    end
                    StRxBlk: begin
                        if (rx_pulse) begin
                            blk_q[8*int'(byte_cnt_q) +: 8] <= rx_data_i;
                            if (byte_cnt_q == BlkLast) begin
                                byte_cnt_q <= '0;
                                state_q    <= StStart;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + CntW'(1);
                            end
                        end
                    end
                    StStart: begin
                        core_start_q <= 1'b1;
                        tmo_cnt_q    <= '0;
                        state_q      <= StWaitCore;
                    end
                    StWaitCore: begin
                        // core_done is tested first so it wins over a coincident timeout.
                        if (core_done_i) begin
                            res_q       <= core_block_out_i;
                            byte_cnt_q  <= '0;
                            tx_single_q <= 1'b0;
                            state_q     <= StTxByte;
                        end else if ((tmo_cnt_q + TmoW'(1)) == TmoLimit) begin
                            err_q   <= 1'b1;
                            state_q <= StTxErr;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
                        end
                    end
                    StTxByte: begin
                        if (tx_ready_i) begin
                            tx_start_q    <= 1'b1;
                            tx_data_q     <= tx_byte;
                            tx_seen_low_q <= 1'b0;
                            state_q       <= StTxWait;
                        end
                    end
                    StTxAck, StTxErr: begin
                        if (tx_ready_i) begin
                            tx_start_q    <= 1'b1;
                            tx_data_q     <= (state_q == StTxAck) ? ACK_BYTE : ERR_BYTE;
                            tx_single_q   <= 1'b1;
                            tx_seen_low_q <= 1'b0;
                            state_q       <= StTxWait;
                        end
                    end
                    StTxWait: begin
                        if (!tx_seen_low_q) begin
                            if (!tx_ready_i) tx_seen_low_q <= 1'b1;
                        end else if (tx_ready_i) begin
                            if (tx_single_q) begin
                                state_q <= StCmd;
                            end else begin
                                gap_cnt_q <= '0;
                                state_q   <= StTxGap;
                            end
                        end
                    end
                    StTxGap: begin
                        if (gap_cnt_q == GapLast) begin
                            if (byte_cnt_q == TxLast) begin
                                byte_cnt_q <= '0;
                                state_q    <= StCmd;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + CntW'(1);
                                state_q    <= StTxByte;
                            end
                        end else begin
                            gap_cnt_q <= gap_cnt_q + GapW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign tx_start_o      = tx_start_q;
    assign tx_data_o       = tx_data_q;
    assign core_key_o      = key_q;
    assign core_block_in_o = blk_q;
    assign core_mode_o     = mode_q;
    assign core_start_o    = core_start_q;
    assign busy_o          = (state_q != StIdle);
    assign key_loaded_o    = key_loaded_q;
    assign err_sticky_o    = err_q;

endmodule
